// File: rtl/mem_scan_check.sv
// mem_scan_check
//   Small register array with a single write port, a registered read port and
//   a built-in scan engine. On start, the scan walks every word from the top
//   index down to the lowest index, one word per clock. It compares each word
//   against an expected pattern derived from the word's own index. It then
//   reports the mismatch count and a pass flag.
//
//   Parameters
//     WIDTH   word width
//     DEPTH   number of words
//     BASE    lowest index; the words live at BASE .. BASE+DEPTH-1
//     ADDR_W  address width (must hold BASE+DEPTH-1)
//     MODE    expected pattern: 0 = index, 1 = ~index, 2 = index ^ SEED
//     SEED    XOR constant used by MODE 2
//
//   Ports
//     clk, rst             rising-edge clock, asynchronous active-high reset
//     wr_en/wr_addr/wr_data  write port; out-of-range addresses are dropped
//     rd_en/rd_addr        read request; the result appears one cycle later
//     rd_data/rd_valid     read result (0 for an out-of-range address)
//     start                begin a scan (only honoured while idle)
//     busy                 high for the DEPTH cycles of a scan
//     done                 one-cycle pulse after the last compare
//     pass                 last completed scan found no mismatches
//     err_count            saturating mismatch count of the last/current scan
//
//   Optional feature (macro MEM_SCAN_CHECK_ERRLOG_EN)
//     err_addr/err_data    index and contents of the first mismatching word
//                          in scan order
module mem_scan_check #(
  parameter int               WIDTH  = 32,
  parameter int               DEPTH  = 16,
  parameter int               BASE   = 1,
  parameter int               ADDR_W = 5,
  parameter int               MODE   = 0,
  parameter logic [WIDTH-1:0] SEED   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count
`ifdef MEM_SCAN_CHECK_ERRLOG_EN
  ,
  output logic [ADDR_W-1:0] err_addr,
  output logic [WIDTH-1:0]  err_data
`endif
);

  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LO      = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] HI      = ADDR_W'(BASE + DEPTH - 1);
  localparam logic [ADDR_W:0]   NWORDS  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t            state;
  state_t            next_state;
  logic [WIDTH-1:0]  mem [0:DEPTH-1];
  logic [ADDR_W-1:0] wr_off;
  logic [ADDR_W-1:0] rd_off;
  logic [ADDR_W-1:0] ptr;
  logic              wr_hit;
  logic              rd_hit;
  logic [WIDTH-1:0]  scan_word;
  logic              mismatch;

  // Expected contents of a word: its index zero-extended (or truncated) to
  // WIDTH, then transformed according to MODE.
  function automatic logic [WIDTH-1:0] expected_word(input logic [ADDR_W-1:0] idx);
    logic [WIDTH-1:0] raw;
    raw = '0;
    for (int b = 0; b < WIDTH && b < ADDR_W; b++) begin
      raw[b] = idx[b];
    end
    case (MODE)
      1:       expected_word = ~raw;
      2:       expected_word = raw ^ SEED;
      default: expected_word = raw;
    endcase
  endfunction

  // Addresses are rebased to zero. An address below BASE wraps to a large
  // value, so a single unsigned compare against DEPTH is enough to detect an
  // out-of-range address on either side.
  assign wr_off    = wr_addr - LO;
  assign rd_off    = rd_addr - LO;
  assign wr_hit    = ({1'b0, wr_off} < NWORDS);
  assign rd_hit    = ({1'b0, rd_off} < NWORDS);
  assign scan_word = mem[IDX_W'(ptr - LO)];
  assign mismatch  = (scan_word != expected_word(ptr));

  // The array storage has no reset, so its contents survive rst. Reads and
  // compares in the same cycle see the value from before this write.
  always_ff @(posedge clk) begin
    if (wr_en && wr_hit) begin
      mem[IDX_W'(wr_off)] <= wr_data;
    end
  end

  // The read port runs independently of the scan. rd_data keeps its last
  // value when there is no request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (rd_en) begin
      rd_valid <= 1'b1;
      rd_data  <= rd_hit ? mem[IDX_W'(rd_off)] : '0;
    end else begin
      rd_valid <= 1'b0;
    end
  end

  // Scan FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. busy and done decode directly from the state, so reset
  // clears them immediately.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = SCAN;
        end
      end
      SCAN: begin
        busy = 1'b1;
        if (ptr == LO) begin
          next_state = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Scan datapath. The pointer stops at LO, and the FSM leaves SCAN on that
  // same compare. pass is cleared while a new scan is in flight and is only
  // settled in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= HI;
      err_count <= '0;
      pass      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ptr       <= HI;
            err_count <= '0;
            pass      <= 1'b0;
          end
        end
        SCAN: begin
          if (mismatch && (err_count != '1)) begin
            err_count <= err_count + CNT_ONE;
          end
          if (ptr != LO) begin
            ptr <= ptr - PTR_ONE;
          end
        end
        DONE: begin
          pass <= (err_count == '0);
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_SCAN_CHECK_ERRLOG_EN
  // First-mismatch log. A zero err_count means no mismatch has been seen yet
  // in this scan, because the count never wraps back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_addr <= '0;
      err_data <= '0;
    end else if ((state == IDLE) && start) begin
      err_addr <= '0;
      err_data <= '0;
    end else if ((state == SCAN) && mismatch && (err_count == '0)) begin
      err_addr <= ptr;
      err_data <= scan_word;
    end
  end
`endif

endmodule

// File: tb/tb_mem_scan_check.sv
`timescale 1ns/1ps
// Bench for mem_scan_check: one default instance (A) and one small ~index
// instance (B, WIDTH=8, DEPTH=4, BASE=0, MODE=1).
module tb_mem_scan_check;

  localparam int AW = 5;
  localparam int WA = 32;
  localparam int WB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a, rst_b;
  logic          a_wr_en, a_rd_en, a_start, a_rd_valid, a_busy, a_done, a_pass;
  logic [AW-1:0] a_wr_addr, a_rd_addr;
  logic [WA-1:0] a_wr_data, a_rd_data;
  logic [AW:0]   a_err_count;
  logic          b_wr_en, b_rd_en, b_start, b_rd_valid, b_busy, b_done, b_pass;
  logic [AW-1:0] b_wr_addr, b_rd_addr;
  logic [WB-1:0] b_wr_data, b_rd_data;
  logic [AW:0]   b_err_count;
`ifdef MEM_SCAN_CHECK_ERRLOG_EN
  logic [AW-1:0] a_err_addr, b_err_addr;
  logic [WA-1:0] a_err_data;
  logic [WB-1:0] b_err_data;
`endif

  mem_scan_check dut_a (
    .clk(clk), .rst(rst_a), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
    .start(a_start), .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err_count)
`ifdef MEM_SCAN_CHECK_ERRLOG_EN
    , .err_addr(a_err_addr), .err_data(a_err_data)
`endif
  );

  mem_scan_check #(.WIDTH(WB), .DEPTH(4), .BASE(0), .ADDR_W(AW), .MODE(1)) dut_b (
    .clk(clk), .rst(rst_b), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .start(b_start), .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err_count)
`ifdef MEM_SCAN_CHECK_ERRLOG_EN
    , .err_addr(b_err_addr), .err_data(b_err_data)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference contents of instance A and the read result it should show.
  logic [WA-1:0] ma [1:16];
  logic [WA-1:0] exp_rd_a;
  logic          exp_rdv_a;

  typedef struct {
    string         name;
    logic          we;
    int            wa;
    logic [WA-1:0] wd;
    logic          re;
    int            ra;
    logic          exp_valid;
    logic [WA-1:0] exp_data;
  } vec_t;

  vec_t vecs [13];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // One clock of instance A. The read expectation is taken from the model
  // before this cycle's write lands, which gives read-old-data semantics.
  task automatic applyStimulus(input logic we, input int wa, input logic [WA-1:0] wd,
                               input logic re, input int ra, input logic st);
    a_wr_en = we; a_wr_addr = AW'(wa); a_wr_data = wd;
    a_rd_en = re; a_rd_addr = AW'(ra); a_start = st;
    if (re) begin
      exp_rdv_a = 1'b1;
      exp_rd_a  = (ra >= 1 && ra <= 16) ? ma[ra] : '0;
    end else begin
      exp_rdv_a = 1'b0;
    end
    if (we && wa >= 1 && wa <= 16) ma[wa] = wd;
    @(posedge clk); #1;
    a_wr_en = 1'b0; a_rd_en = 1'b0; a_start = 1'b0;
    checkOutput("a_rd_valid", 64'(a_rd_valid), 64'(exp_rdv_a));
    checkOutput("a_rd_data", 64'(a_rd_data), 64'(exp_rd_a));
  endtask

  task automatic stepB(input logic we, input int wa, input logic [WB-1:0] wd,
                       input logic re, input int ra, input logic st);
    b_wr_en = we; b_wr_addr = AW'(wa); b_wr_data = wd;
    b_rd_en = re; b_rd_addr = AW'(ra); b_start = st;
    @(posedge clk); #1;
    b_wr_en = 1'b0; b_rd_en = 1'b0; b_start = 1'b0;
  endtask

  function automatic int modelCountA();
    int cnt = 0;
    for (int i = 1; i <= 16; i++) if (ma[i] !== WA'(i)) cnt++;
    return (cnt > 63) ? 63 : cnt;
  endfunction

`ifdef MEM_SCAN_CHECK_ERRLOG_EN
  // The first mismatch in descending scan order is the highest bad index.
  function automatic logic [AW+WA-1:0] modelFirstA();
    for (int i = 16; i >= 1; i--) if (ma[i] !== WA'(i)) return {AW'(i), ma[i]};
    return '0;
  endfunction
`endif

  // Full scan on instance A: start, optional re-start mid-scan, optional
  // concurrent random reads; checks timing and the final result.
  task automatic scanA(input int exp_cnt, input bit restart, input bit rd_during, input string tag);
    int busy_cycles = 0;
    int done_t = 0;
`ifdef MEM_SCAN_CHECK_ERRLOG_EN
    logic [AW+WA-1:0] first = modelFirstA();
`endif
    applyStimulus(1'b0, 0, '0, 1'b0, 0, 1'b1);
    for (int t = 1; t <= 40; t++) begin
      if (a_done) begin
        done_t = t;
        break;
      end
      if (a_busy) busy_cycles++;
      applyStimulus(1'b0, 0, '0, rd_during && ($urandom_range(0, 1) == 1),
                    int'($urandom_range(0, 20)), restart && (t == 3));
    end
    checkOutput({tag, "_done_cycle"}, 64'(done_t), 64'(17));
    checkOutput({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(16));
    applyStimulus(1'b0, 0, '0, 1'b0, 0, 1'b0);
    checkOutput({tag, "_done_low"}, 64'(a_done), 64'(0));
    checkOutput({tag, "_busy_low"}, 64'(a_busy), 64'(0));
    checkOutput({tag, "_err_count"}, 64'(a_err_count), 64'(exp_cnt));
    checkOutput({tag, "_pass"}, 64'(a_pass), 64'(exp_cnt == 0));
`ifdef MEM_SCAN_CHECK_ERRLOG_EN
    checkOutput({tag, "_err_addr"}, 64'(a_err_addr), 64'(first[AW+WA-1:WA]));
    checkOutput({tag, "_err_data"}, 64'(a_err_data), 64'(first[WA-1:0]));
`endif
  endtask

  task automatic scanB(input int exp_cnt, input int wr_t, input int wa, input logic [WB-1:0] wd, input string tag);
    int busy_cycles = 0;
    int done_t = 0;
    stepB(1'b0, 0, '0, 1'b0, 0, 1'b1);
    for (int t = 1; t <= 20; t++) begin
      if (b_done) begin
        done_t = t;
        break;
      end
      if (b_busy) busy_cycles++;
      stepB(t == wr_t, wa, wd, 1'b0, 0, 1'b0);
    end
    checkOutput({tag, "_done_cycle"}, 64'(done_t), 64'(5));
    checkOutput({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(4));
    stepB(1'b0, 0, '0, 1'b0, 0, 1'b0);
    checkOutput({tag, "_err_count"}, 64'(b_err_count), 64'(exp_cnt));
    checkOutput({tag, "_pass"}, 64'(b_pass), 64'(exp_cnt == 0));
  endtask

  // Watchdog: the run must end on its own even if a scan never completes.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int cnt;
    vecs[0]  = '{"rd7",        1'b0, 0,  '0,           1'b1, 7,  1'b1, 32'd7};
    vecs[1]  = '{"rd0_oor",    1'b0, 0,  '0,           1'b1, 0,  1'b1, 32'd0};
    vecs[2]  = '{"rd16",       1'b0, 0,  '0,           1'b1, 16, 1'b1, 32'd16};
    vecs[3]  = '{"rd17_oor",   1'b0, 0,  '0,           1'b1, 17, 1'b1, 32'd0};
    vecs[4]  = '{"idle_hold0", 1'b0, 0,  '0,           1'b0, 0,  1'b0, 32'd0};
    vecs[5]  = '{"rd9",        1'b0, 0,  '0,           1'b1, 9,  1'b1, 32'd9};
    vecs[6]  = '{"idle_hold9", 1'b0, 0,  '0,           1'b0, 0,  1'b0, 32'd9};
    vecs[7]  = '{"rdwr3_old",  1'b1, 3,  32'hAAAA,     1'b1, 3,  1'b1, 32'd3};
    vecs[8]  = '{"rd3_new",    1'b0, 0,  '0,           1'b1, 3,  1'b1, 32'hAAAA};
    vecs[9]  = '{"wr0_ign",    1'b1, 0,  32'hDEAD,     1'b1, 1,  1'b1, 32'd1};
    vecs[10] = '{"wr17_ign",   1'b1, 17, 32'hBEEF,     1'b1, 16, 1'b1, 32'd16};
    vecs[11] = '{"rd1_noalias",1'b1, 3,  32'd3,        1'b1, 1,  1'b1, 32'd1};
    vecs[12] = '{"rd3_back",   1'b0, 0,  '0,           1'b1, 3,  1'b1, 32'd3};

    rst_a = 1'b1; rst_b = 1'b1;
    a_wr_en = 0; a_wr_addr = '0; a_wr_data = '0; a_rd_en = 0; a_rd_addr = '0; a_start = 0;
    b_wr_en = 0; b_wr_addr = '0; b_wr_data = '0; b_rd_en = 0; b_rd_addr = '0; b_start = 0;
    exp_rd_a = '0; exp_rdv_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", 64'(a_busy), 64'(0));
    checkOutput("rst_done", 64'(a_done), 64'(0));
    checkOutput("rst_pass", 64'(a_pass), 64'(0));
    checkOutput("rst_err_count", 64'(a_err_count), 64'(0));
    checkOutput("rst_rd_valid", 64'(a_rd_valid), 64'(0));
    checkOutput("rst_rd_data", 64'(a_rd_data), 64'(0));
    checkOutput("rst_b_busy", 64'(b_busy), 64'(0));
`ifdef MEM_SCAN_CHECK_ERRLOG_EN
    checkOutput("rst_err_addr", 64'(a_err_addr), 64'(0));
    checkOutput("rst_err_data", 64'(a_err_data), 64'(0));
`endif
    rst_a = 1'b0; rst_b = 1'b0;

    $display("[TB] fill and directed reads");
    for (int i = 1; i <= 16; i++) applyStimulus(1'b1, i, WA'(i), 1'b0, 0, 1'b0);
    foreach (vecs[k]) begin
      applyStimulus(vecs[k].we, vecs[k].wa, vecs[k].wd, vecs[k].re, vecs[k].ra, 1'b0);
      checkOutput({"tbl_", vecs[k].name, "_valid"}, 64'(a_rd_valid), 64'(vecs[k].exp_valid));
      checkOutput({"tbl_", vecs[k].name, "_data"}, 64'(a_rd_data), 64'(vecs[k].exp_data));
    end

    $display("[TB] clean scan and two-error scan");
    scanA(0, 1'b0, 1'b0, "clean");
    applyStimulus(1'b1, 5, 32'h55, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, 12, 32'h0, 1'b0, 0, 1'b0);
    scanA(2, 1'b0, 1'b0, "two_err");
`ifdef MEM_SCAN_CHECK_ERRLOG_EN
    checkOutput("two_err_addr_const", 64'(a_err_addr), 64'(12));
    checkOutput("two_err_data_const", 64'(a_err_data), 64'(0));
`endif
    applyStimulus(1'b1, 5, 32'd5, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, 12, 32'd12, 1'b0, 0, 1'b0);

    $display("[TB] restart ignored, reset mid-scan");
    scanA(0, 1'b1, 1'b0, "restart");
    applyStimulus(1'b1, 16, 32'h1234, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, 0, '0, 1'b0, 0, 1'b1);
    for (int t = 1; t < 4; t++) applyStimulus(1'b0, 0, '0, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, 0, '0, 1'b1, 10, 1'b0);
    checkOutput("mid_err_count", 64'(a_err_count), 64'(1));
    checkOutput("mid_busy", 64'(a_busy), 64'(1));
    #2 rst_a = 1'b1;
    #1;
    checkOutput("abort_busy", 64'(a_busy), 64'(0));
    checkOutput("abort_err_count", 64'(a_err_count), 64'(0));
    checkOutput("abort_rd_valid", 64'(a_rd_valid), 64'(0));
    checkOutput("abort_rd_data", 64'(a_rd_data), 64'(0));
    exp_rd_a = '0; exp_rdv_a = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_done", 64'(a_done), 64'(0));
    rst_a = 1'b0;
    scanA(1, 1'b0, 1'b0, "survive");
    applyStimulus(1'b1, 16, 32'd16, 1'b0, 0, 1'b0);
    scanA(0, 1'b0, 1'b0, "after_rst");

    $display("[TB] inverted-index instance");
    for (int i = 0; i < 4; i++) stepB(1'b1, i, ~WB'(i), 1'b0, 0, 1'b0);
    stepB(1'b0, 0, '0, 1'b1, 1, 1'b0);
    checkOutput("b_rd1", 64'(b_rd_data), 64'(8'hFE));
    scanB(0, 0, 0, '0, "b_clean");
    scanB(0, 2, 2, 8'h02, "b_wr_under_cmp");
    scanB(1, 0, 0, '0, "b_next");
`ifdef MEM_SCAN_CHECK_ERRLOG_EN
    checkOutput("b_err_addr", 64'(b_err_addr), 64'(2));
    checkOutput("b_err_data", 64'(b_err_data), 64'(8'h02));
`endif

    $display("[TB] randomized scans");
    for (int it = 0; it < 12; it++) begin
      int nw = int'($urandom_range(2, 6));
      for (int w = 0; w < nw; w++) begin
        int wa = int'($urandom_range(0, 20));
        logic [WA-1:0] wd = ($urandom_range(0, 2) == 0) ? WA'($urandom) : WA'(wa);
        applyStimulus(1'b1, wa, wd, $urandom_range(0, 1) == 1, int'($urandom_range(0, 20)), 1'b0);
      end
      cnt = modelCountA();
      scanA(cnt, $urandom_range(0, 1) == 1, 1'b1, "rand");
    end

    $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
